// File: rtl/mem_byte_streamer.sv
// mem_byte_streamer: reads a block of memory as 32-bit words through the
// memory controller request port and replays it as a byte stream, least
// significant byte of each word first. A trailing partial word only emits
// the bytes that fall inside the requested length.
module mem_byte_streamer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk27mhz,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [7:0]        w_ctrl_state,
    output logic              RD_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [31:0]       RDATA,
    input  logic              RVALID,
    output logic [7:0]        outbyte,
    output logic              outvalid,
    input  logic              outready,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SEND   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic              rd_req_q, rd_req_d;
    logic              outvalid_q, outvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic ctrl_idle;
    logic handshake;

    assign ctrl_idle = (w_ctrl_state == 8'd0);
    assign handshake = outvalid_q && outready;

    // Next-state logic for the transfer sequencer and its datapath registers.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        word_d     = word_q;
        idx_d      = idx_q;
        rd_req_d   = rd_req_q;
        outvalid_d = outvalid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d   = base_addr & ~ADDR_W'(3);
                        remain_d = length;
                        done_d   = 1'b0;
                        busy_d   = 1'b1;
                        // Raise the request immediately when the controller is free
                        // so the read goes out in the first busy cycle.
                        rd_req_d = ctrl_idle;
                        state_d  = S_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (rd_req_q) begin
                    // Controller leaving idle while we request means it took the read.
                    if (!ctrl_idle) begin
                        rd_req_d = 1'b0;
                        state_d  = S_WAIT;
                    end
                end else if (ctrl_idle) begin
                    rd_req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (RVALID) begin
                    word_d     = RDATA;
                    idx_d      = 2'd0;
                    addr_d     = addr_q + ADDR_W'(4);
                    outvalid_d = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    remain_d = remain_q - ADDR_W'(1);
                    idx_d    = idx_q + 2'd1;
                    if (remain_q == ADDR_W'(1)) begin
                        outvalid_d = 1'b0;
                        state_d    = S_FINISH;
                    end else if (idx_q == 2'd3) begin
                        outvalid_d = 1'b0;
                        rd_req_d   = ctrl_idle;
                        state_d    = S_REQ;
                    end
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                rd_req_d   = 1'b0;
                outvalid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any in-flight read.
    always_ff @(posedge clk27mhz or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            rd_req_q   <= 1'b0;
            outvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            rd_req_q   <= rd_req_d;
            outvalid_q <= outvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign RD_REQ   = rd_req_q;
    assign RD_ADDR  = addr_q;
    assign outbyte  = word_q[{idx_q, 3'b000} +: 8];
    assign outvalid = outvalid_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_mem_byte_streamer.sv
// Testbench for mem_byte_streamer: a behavioural memory controller and byte
// sink surround the DUT; expected streams come from a word/byte model.
`timescale 1ns/1ps
module tb_mem_byte_streamer;
    typedef logic [7:0]  q8_t[$];
    typedef logic [31:0] q32_t[$];

    logic        clk27mhz = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] length = '0;
    logic [7:0]  w_ctrl_state;
    logic        RD_REQ;
    logic [31:0] RD_ADDR;
    logic [31:0] RDATA;
    logic        RVALID;
    logic [7:0]  outbyte;
    logic        outvalid;
    logic        outready;
    logic        BUSY;
    logic        DONE;

    logic [31:0] mem [logic [31:0]];
    logic        ctrl_busy = 1'b0, ctrl_rvalid = 1'b0;
    logic [31:0] ctrl_rdata = '0, ctrl_addr = '0;
    int          ctrl_lat = 0;
    logic        force_busy = 1'b0, stray_rvalid = 1'b0, stall = 1'b0, rand_ready = 1'b0;
    q32_t        req_log;
    q8_t         byte_log;
    int          stall_viol = 0;
    logic        prev_stalled = 1'b0;
    logic [7:0]  prev_byte = '0;
    int          checks = 0, errors = 0;

    assign w_ctrl_state = force_busy ? 8'd5 : (ctrl_busy ? 8'd1 : 8'd0);
    assign RVALID       = ctrl_rvalid | stray_rvalid;
    assign RDATA        = ctrl_rdata;

    mem_byte_streamer #(.ADDR_W(32)) dut (
        .clk27mhz(clk27mhz), .resetn(resetn), .start(start),
        .base_addr(base_addr), .length(length), .w_ctrl_state(w_ctrl_state),
        .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RDATA(RDATA), .RVALID(RVALID),
        .outbyte(outbyte), .outvalid(outvalid), .outready(outready),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #18 clk27mhz = ~clk27mhz;

    // Memory controller: accepts a request by going busy, answers after a random latency.
    initial begin
        forever begin
            @(posedge clk27mhz); #1;
            if (!resetn) begin
                ctrl_busy = 1'b0; ctrl_rvalid = 1'b0; ctrl_lat = 0;
            end else if (ctrl_rvalid) begin
                ctrl_rvalid = 1'b0; ctrl_busy = 1'b0;
            end else if (ctrl_busy) begin
                if (ctrl_lat == 0) begin
                    ctrl_rvalid = 1'b1;
                    ctrl_rdata  = mem.exists(ctrl_addr) ? mem[ctrl_addr] : 32'hDEADBEEF;
                end else begin
                    ctrl_lat = ctrl_lat - 1;
                end
            end else if (RD_REQ && !force_busy) begin
                ctrl_busy = 1'b1;
                ctrl_addr = RD_ADDR;
                req_log.push_back(RD_ADDR);
                ctrl_lat  = $urandom_range(0, 3);
            end
        end
    end

    // Byte sink: drives outready mid-cycle and logs every byte that will be accepted.
    initial begin
        outready = 1'b0;
        forever begin
            @(negedge clk27mhz);
            if (resetn && prev_stalled && (!outvalid || outbyte !== prev_byte))
                stall_viol = stall_viol + 1;
            outready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (resetn && outvalid && outready) byte_log.push_back(outbyte);
            prev_stalled = resetn && outvalid && !outready;
            prev_byte    = outbyte;
        end
    end

    // Reference model: byte i of the block is byte (i mod 4) of word (i / 4).
    function automatic q8_t model_bytes(input logic [31:0] base, input int len);
        q8_t q;
        logic [31:0] a, w;
        for (int i = 0; i < len; i++) begin
            a = (base & 32'hFFFF_FFFC) + 32'(4 * (i / 4));
            w = mem.exists(a) ? mem[a] : 32'hDEADBEEF;
            q.push_back(w[8 * (i % 4) +: 8]);
        end
        return q;
    endfunction

    function automatic q32_t model_addrs(input logic [31:0] base, input int len);
        q32_t q;
        for (int k = 0; k < (len + 3) / 4; k++) q.push_back((base & 32'hFFFF_FFFC) + 32'(4 * k));
        return q;
    endfunction

    task automatic fill_mem(input logic [31:0] base, input int len);
        q32_t a = model_addrs(base, len);
        foreach (a[k]) mem[a[k]] = $urandom;
    endtask

    task automatic launch(input logic [31:0] b, input logic [31:0] l);
        @(negedge clk27mhz);
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk27mhz); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(posedge clk27mhz); #1;
            if (DONE && !BUSY) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk27mhz);
        @(negedge clk27mhz);
        checks++; if (RD_REQ !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b exp 0", RD_REQ); end
        checks++; if (RD_ADDR !== 32'h0) begin errors++; $display("FAIL reset_rd_addr got %h exp 0", RD_ADDR); end
        checks++; if (outvalid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b exp 0", outvalid); end
        checks++; if (outbyte !== 8'h0) begin errors++; $display("FAIL reset_outbyte got %h exp 00", outbyte); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
        resetn = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_zero_length;
        int nreq = req_log.size();
        bit seen = 1'b0;
        launch(32'h40, 32'd0);
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", DONE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", BUSY); end
        repeat (6) begin
            @(posedge clk27mhz); #1;
            if (RD_REQ || outvalid || BUSY) seen = 1'b1;
        end
        checks++; if (seen || req_log.size() != nreq) begin
            errors++; $display("FAIL zero_activity got seen=%b reads=%0d exp seen=0 reads=0", seen, req_log.size() - nreq);
        end
        $display("xfer base=00000040 len=0 done=%b", DONE);
    endtask

    task automatic test_basic;
        q8_t exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        q32_t exp_a = '{32'h100, 32'h104};
        int sb = byte_log.size(), sa = req_log.size(), nbad = 0;
        bit ok;
        mem[32'h100] = 32'h44332211; mem[32'h104] = 32'h88776655;
        rand_ready = 1'b0;
        launch(32'h100, 32'd8);
        checks++; if (BUSY !== 1'b1 || RD_REQ !== 1'b1 || DONE !== 1'b0) begin
            errors++; $display("FAIL basic_first_cycle got busy=%b req=%b done=%b exp 1 1 0", BUSY, RD_REQ, DONE);
        end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got busy=%b done=%b exp 0 1", BUSY, DONE); end
        checks++; if (outvalid !== 1'b0) begin errors++; $display("FAIL basic_outvalid_end got %b exp 0", outvalid); end
        for (int i = 0; i < exp_b.size(); i++)
            if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
        checks++; if (nbad != 0 || byte_log.size() - sb != exp_b.size()) begin
            errors++; $display("FAIL basic_bytes got %0d bytes %0d wrong exp %0d bytes", byte_log.size() - sb, nbad, exp_b.size());
        end
        nbad = 0;
        for (int i = 0; i < exp_a.size(); i++)
            if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
        checks++; if (nbad != 0 || req_log.size() - sa != exp_a.size()) begin
            errors++; $display("FAIL basic_reads got %0d reads %0d wrong exp %0d", req_log.size() - sa, nbad, exp_a.size());
        end
        $display("xfer base=00000100 len=8 bytes=%0d reads=%0d", byte_log.size() - sb, req_log.size() - sa);
    endtask

    task automatic test_partial;
        q8_t exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        q32_t exp_a = '{32'h200, 32'h204};
        int sb = byte_log.size(), sa = req_log.size(), nbad = 0;
        bit ok;
        mem[32'h200] = 32'hDDCCBBAA; mem[32'h204] = 32'h000000EE;
        rand_ready = 1'b1;
        launch(32'h203, 32'd5);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_timeout got busy=%b done=%b exp 0 1", BUSY, DONE); end
        for (int i = 0; i < exp_b.size(); i++)
            if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
        checks++; if (nbad != 0 || byte_log.size() - sb != exp_b.size()) begin
            errors++; $display("FAIL partial_bytes got %0d bytes %0d wrong exp %0d bytes", byte_log.size() - sb, nbad, exp_b.size());
        end
        nbad = 0;
        for (int i = 0; i < exp_a.size(); i++)
            if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
        checks++; if (nbad != 0 || req_log.size() - sa != exp_a.size()) begin
            errors++; $display("FAIL partial_reads got %0d reads %0d wrong exp %0d", req_log.size() - sa, nbad, exp_a.size());
        end
        $display("xfer base=00000203 len=5 bytes=%0d reads=%0d", byte_log.size() - sb, req_log.size() - sa);
    endtask

    task automatic test_backpressure;
        logic [31:0] b = 32'h1000;
        q8_t  exp_b;
        q32_t exp_a;
        int sb = byte_log.size(), sa = req_log.size(), nbad = 0, sv = stall_viol;
        logic [7:0] held;
        bit ok = 1'b0;
        fill_mem(b, 12);
        exp_b = model_bytes(b, 12); exp_a = model_addrs(b, 12);
        rand_ready = 1'b0;
        force_busy = 1'b1;
        launch(b, 32'd12);
        checks++; if (RD_REQ !== 1'b0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL bp_req_while_busy got req=%b busy=%b exp 0 1", RD_REQ, BUSY);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk27mhz); #1;
            checks++; if (RD_REQ !== 1'b0) begin errors++; $display("FAIL bp_req_held_low cyc%0d got %b exp 0", c, RD_REQ); end
        end
        @(negedge clk27mhz); force_busy = 1'b0;
        @(posedge clk27mhz); #1;
        checks++; if (RD_REQ !== 1'b1 || RD_ADDR !== b) begin
            errors++; $display("FAIL bp_req_after_idle got req=%b addr=%h exp 1 %h", RD_REQ, RD_ADDR, b);
        end
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk27mhz); #2;
            if (byte_log.size() >= sb + 2) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_first_bytes got %0d exp 2", byte_log.size() - sb); end
        stall = 1'b1;
        @(negedge clk27mhz); #1;
        held = outbyte;
        checks++; if (outvalid !== 1'b1 || held !== exp_b[2]) begin
            errors++; $display("FAIL bp_stall_byte got valid=%b byte=%h exp 1 %h", outvalid, held, exp_b[2]);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk27mhz); #1;
            checks++; if (outvalid !== 1'b1 || outbyte !== held) begin
                errors++; $display("FAIL bp_hold cyc%0d got valid=%b byte=%h exp 1 %h", c, outvalid, outbyte, held);
            end
        end
        stall = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got busy=%b done=%b exp 0 1", BUSY, DONE); end
        for (int i = 0; i < exp_b.size(); i++)
            if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
        checks++; if (nbad != 0 || byte_log.size() - sb != exp_b.size() || stall_viol != sv) begin
            errors++; $display("FAIL bp_bytes got %0d bytes %0d wrong %0d stall changes exp %0d bytes", byte_log.size() - sb, nbad, stall_viol - sv, exp_b.size());
        end
        nbad = 0;
        for (int i = 0; i < exp_a.size(); i++)
            if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
        checks++; if (nbad != 0 || req_log.size() - sa != exp_a.size()) begin
            errors++; $display("FAIL bp_reads got %0d reads %0d wrong exp %0d", req_log.size() - sa, nbad, exp_a.size());
        end
        $display("xfer base=%h len=12 stall=10 bytes=%0d reads=%0d", b, byte_log.size() - sb, req_log.size() - sa);
    endtask

    task automatic test_reset_midstream;
        logic [31:0] b1 = 32'h2400, b2 = 32'h2800;
        q8_t  exp_b;
        q32_t exp_a;
        int sb = byte_log.size(), sa, nbad = 0;
        bit ok = 1'b0;
        fill_mem(b1, 8); fill_mem(b2, 6);
        rand_ready = 1'b0;
        launch(b1, 32'd8);
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk27mhz); #2;
            if (byte_log.size() >= sb + 3) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_first_bytes got %0d exp 3", byte_log.size() - sb); end
        resetn = 1'b0; #1;
        checks++; if ({RD_REQ, outvalid, BUSY, DONE} !== 4'b0 || RD_ADDR !== 32'h0 || outbyte !== 8'h0) begin
            errors++; $display("FAIL rst_outputs got req=%b val=%b busy=%b done=%b addr=%h byte=%h exp all 0", RD_REQ, outvalid, BUSY, DONE, RD_ADDR, outbyte);
        end
        repeat (3) @(posedge clk27mhz);
        @(negedge clk27mhz); resetn = 1'b1;
        @(negedge clk27mhz); stray_rvalid = 1'b1;
        @(negedge clk27mhz); stray_rvalid = 1'b0;
        @(posedge clk27mhz); #1;
        checks++; if (outvalid !== 1'b0 || BUSY !== 1'b0 || byte_log.size() != sb + 3) begin
            errors++; $display("FAIL rst_stray_rvalid got val=%b busy=%b bytes=%0d exp 0 0 3", outvalid, BUSY, byte_log.size() - sb);
        end
        exp_b = model_bytes(b2, 6); exp_a = model_addrs(b2, 6);
        sb = byte_log.size(); sa = req_log.size();
        launch(b2, 32'd6);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_new_timeout got busy=%b done=%b exp 0 1", BUSY, DONE); end
        for (int i = 0; i < exp_b.size(); i++)
            if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
        for (int i = 0; i < exp_a.size(); i++)
            if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
        checks++; if (nbad != 0 || byte_log.size() - sb != 6 || req_log.size() - sa != 2) begin
            errors++; $display("FAIL rst_new_xfer got %0d bytes %0d reads %0d wrong exp 6 bytes 2 reads", byte_log.size() - sb, req_log.size() - sa, nbad);
        end
        $display("xfer base=%h len=6 after reset bytes=%0d reads=%0d", b2, byte_log.size() - sb, req_log.size() - sa);
    endtask

    task automatic test_start_while_busy;
        logic [31:0] b = 32'h300;
        q8_t  exp_b;
        q32_t exp_a;
        int sb = byte_log.size(), sa = req_log.size(), nbad = 0;
        bit ok = 1'b0;
        fill_mem(b, 10); fill_mem(32'h7000, 3);
        exp_b = model_bytes(b, 10); exp_a = model_addrs(b, 10);
        rand_ready = 1'b1;
        launch(b, 32'd10);
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk27mhz); #2;
            if (outvalid) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL swb_send got outvalid=%b exp 1", outvalid); end
        launch(32'h7000, 32'd3);
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL swb_timeout got busy=%b done=%b exp 0 1", BUSY, DONE); end
        repeat (4) @(posedge clk27mhz);
        #1;
        for (int i = 0; i < exp_b.size(); i++)
            if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
        for (int i = 0; i < exp_a.size(); i++)
            if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
        checks++; if (nbad != 0 || byte_log.size() - sb != 10 || req_log.size() - sa != 3 || BUSY !== 1'b0) begin
            errors++; $display("FAIL swb_xfer got %0d bytes %0d reads %0d wrong busy=%b exp 10 bytes 3 reads busy=0", byte_log.size() - sb, req_log.size() - sa, nbad, BUSY);
        end
        $display("xfer base=%h len=10 second start ignored bytes=%0d reads=%0d", b, byte_log.size() - sb, req_log.size() - sa);
    endtask

    task automatic test_random;
        logic [31:0] b;
        int len, sb, sa, nbad;
        q8_t  exp_b;
        q32_t exp_a;
        bit ok;
        rand_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            b   = (t == 0) ? 32'hFFFF_FFF9 : $urandom;
            len = (t == 0) ? 14 : $urandom_range(1, 23);
            fill_mem(b, len);
            exp_b = model_bytes(b, len); exp_a = model_addrs(b, len);
            sb = byte_log.size(); sa = req_log.size(); nbad = 0;
            launch(b, 32'(len));
            wait_done(ok);
            for (int i = 0; i < exp_b.size(); i++)
                if (sb + i >= byte_log.size() || byte_log[sb + i] !== exp_b[i]) nbad++;
            for (int i = 0; i < exp_a.size(); i++)
                if (sa + i >= req_log.size() || req_log[sa + i] !== exp_a[i]) nbad++;
            checks++; if (!ok || nbad != 0 || byte_log.size() - sb != len || req_log.size() - sa != exp_a.size()) begin
                errors++; $display("FAIL rand%0d base=%h len=%0d got done=%b %0d bytes %0d reads %0d wrong exp %0d reads",
                                   t, b, len, ok, byte_log.size() - sb, req_log.size() - sa, nbad, exp_a.size());
            end
            $display("xfer base=%h len=%0d bytes=%0d reads=%0d", b, len, byte_log.size() - sb, req_log.size() - sa);
        end
    endtask

    initial begin
        test_reset;
        test_zero_length;
        test_basic;
        test_partial;
        test_backpressure;
        test_reset_midstream;
        test_start_while_busy;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
